// File: rtl/z80_seq_pkg.sv
// Shared types for the Z80 control-pin sequencer: pin select, queued event, FSM state.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
//
// The event delay field is sized for the widest delay any instance may use
// (SEQ_DELAY_W_MAX). Each instance zero-extends its own DELAY_W-bit delay into
// it, so the upper bits are constant and drop out of the FIFO storage.
// Instances must keep DELAY_W <= SEQ_DELAY_W_MAX.
package z80_seq_pkg;

    typedef enum logic [1:0] {
        PIN_NRESET = 2'd0,
        PIN_NINT   = 2'd1,
        PIN_NNMI   = 2'd2,
        PIN_NBUSRQ = 2'd3
    } pin_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_ACKWAIT = 2'd2
    } seq_state_e;

    localparam int SEQ_DELAY_W_MAX = 32;

    typedef struct packed {
        pin_sel_e                   pin;
        logic                       level;
        logic                       wack;
        logic [SEQ_DELAY_W_MAX-1:0] delay;
    } seq_evt_t;

    // Pin vector indexed by pin_sel_e: bit0 nRESET held asserted, the rest idle high.
    localparam logic [3:0] PINS_RST = 4'b1110;

    // An event waits for bus acknowledge only when it asserts BUSRQ and asks to.
    function automatic logic evt_needs_ack(input pin_sel_e pin, input logic level,
                                           input logic wack);
        return (pin == PIN_NBUSRQ) && !level && wack;
    endfunction

endpackage

// File: rtl/z80_seq_fifo.sv
// Event FIFO for the control-pin sequencer, DEPTH entries of type T.
// Latency: a push is visible at the head on the next cycle; the head is read combinationally.
// Backpressure: full refuses pushes (a same-cycle pop does not free space); flush wins over push/pop.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush             empty the queue on this edge, same-edge push dropped
//   push, push_dat    write request and entry (ignored while full)
//   full              DEPTH entries held
//   pop, pop_dat      read request and current head entry
//   empty             no entries held
//   level             occupancy 0..DEPTH
module z80_seq_fifo
    import z80_seq_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = seq_evt_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  T                         push_dat,
    output logic                     full,
    input  logic                     pop,
    output T                         pop_dat,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    cnt;
    logic           do_push;
    logic           do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign pop_dat = mem[rd_ptr];

    // Reset and flush both discard a same-edge push, so gate the write here too.
    assign do_push = rst_n && !flush && push && !full;
    assign do_pop  = rst_n && !flush && pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/z80_ctl_seq.sv
// Timed sequencer driving Z80 control pins (nRESET/nINT/nNMI/nBUSRQ) from a queue of events.
// Latency: event pushed into an idle, empty sequencer on edge k changes its pin on edge k+delay+2.
// Backpressure: push_ready = FIFO not full; events run one at a time, delay+2 cycles each.
//
// Ports:
//   CLK, nRESET                        clock, synchronous active-low reset
//   push_valid/push_ready              event handshake
//   push_pin/push_level/push_wack/push_delay   event fields
//   flush                              drop queue and abort current event, pins unchanged
//   tmo_clr                            clear sticky timeout flag (a same-edge set wins)
//   nBUSACK                            CPU bus acknowledge, active low
//   cpu_nRESET/cpu_nINT/cpu_nNMI/cpu_nBUSRQ    registered pin outputs
//   busy                               event in progress or queued
//   level                              FIFO occupancy
//   tmo                                sticky BUSACK timeout flag
module z80_ctl_seq
    import z80_seq_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DELAY_W = 16,
    parameter int TMO_W   = 8
) (
    input  logic                     CLK,
    input  logic                     nRESET,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [1:0]               push_pin,
    input  logic                     push_level,
    input  logic                     push_wack,
    input  logic [DELAY_W-1:0]       push_delay,
    input  logic                     flush,
    input  logic                     tmo_clr,
    input  logic                     nBUSACK,
    output logic                     cpu_nRESET,
    output logic                     cpu_nINT,
    output logic                     cpu_nNMI,
    output logic                     cpu_nBUSRQ,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     tmo
);

    // Timeout fires on the edge that completes 2**TMO_W-1 ACKWAIT cycles,
    // i.e. when the cycle counter (cleared on entry) already holds limit-1.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2 ** TMO_W) - 2);

    seq_evt_t            push_evt;
    seq_evt_t            head_evt;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic                unused_head_dly;

    seq_state_e          state_q,     state_d;
    logic [DELAY_W-1:0]  dly_q,       dly_d;
    logic [TMO_W-1:0]    ack_q,       ack_d;
    pin_sel_e            cur_pin_q,   cur_pin_d;
    logic                cur_level_q, cur_level_d;
    logic                cur_wack_q,  cur_wack_d;
    logic [3:0]          pins_q,      pins_d;
    logic                tmo_q,       tmo_d;

    assign push_evt = '{pin:   pin_sel_e'(push_pin),
                        level: push_level,
                        wack:  push_wack,
                        delay: SEQ_DELAY_W_MAX'(push_delay)};

    // Bits above DELAY_W are always zero in stored events.
    assign unused_head_dly = ^head_evt.delay;

    z80_seq_fifo #(
        .DEPTH (DEPTH),
        .T     (seq_evt_t)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (nRESET),
        .flush    (flush),
        .push     (push_valid),
        .push_dat (push_evt),
        .full     (fifo_full),
        .pop      (fifo_pop),
        .pop_dat  (head_evt),
        .empty    (fifo_empty),
        .level    (level)
    );

    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        ack_d       = ack_q;
        cur_pin_d   = cur_pin_q;
        cur_level_d = cur_level_q;
        cur_wack_d  = cur_wack_q;
        pins_d      = pins_q;
        tmo_d       = tmo_q && !tmo_clr;
        fifo_pop    = 1'b0;

        if (flush) begin
            // Abort whatever is in flight; the pins hold their present levels.
            state_d = ST_IDLE;
            dly_d   = '0;
            ack_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop    = 1'b1;
                        cur_pin_d   = head_evt.pin;
                        cur_level_d = head_evt.level;
                        cur_wack_d  = head_evt.wack;
                        dly_d       = head_evt.delay[DELAY_W-1:0];
                        state_d     = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (dly_q != '0) begin
                        dly_d = dly_q - DELAY_W'(1);
                    end else begin
                        pins_d[cur_pin_q] = cur_level_q;
                        if (evt_needs_ack(cur_pin_q, cur_level_q, cur_wack_q)) begin
                            ack_d   = '0;
                            state_d = ST_ACKWAIT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_ACKWAIT: begin
                    // Acknowledge takes priority over a timeout on the same edge.
                    if (!nBUSACK) begin
                        state_d = ST_IDLE;
                    end else if (ack_q == TMO_LAST) begin
                        tmo_d              = 1'b1;
                        pins_d[PIN_NBUSRQ] = 1'b1;
                        ack_d              = '0;
                        state_d            = ST_IDLE;
                    end else begin
                        ack_d = ack_q + TMO_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_q     <= ST_IDLE;
            dly_q       <= '0;
            ack_q       <= '0;
            cur_pin_q   <= PIN_NRESET;
            cur_level_q <= 1'b0;
            cur_wack_q  <= 1'b0;
            pins_q      <= PINS_RST;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            ack_q       <= ack_d;
            cur_pin_q   <= cur_pin_d;
            cur_level_q <= cur_level_d;
            cur_wack_q  <= cur_wack_d;
            pins_q      <= pins_d;
            tmo_q       <= tmo_d;
        end
    end

    assign cpu_nRESET = pins_q[PIN_NRESET];
    assign cpu_nINT   = pins_q[PIN_NINT];
    assign cpu_nNMI   = pins_q[PIN_NNMI];
    assign cpu_nBUSRQ = pins_q[PIN_NBUSRQ];
    assign tmo        = tmo_q;
    assign push_ready = !fifo_full;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_z80_ctl_seq.sv
// Directed bench for z80_ctl_seq with an event-schedule reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_z80_ctl_seq;

    localparam int DEPTH = 8;
    localparam int LIMIT = 15;   // 2**TMO_W-1 with TMO_W=4

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [1:0]  push_pin = 2'd0;
    logic        push_level = 1'b0;
    logic        push_wack = 1'b0;
    logic [15:0] push_delay = 16'd0;
    logic        flush = 1'b0;
    logic        tmo_clr = 1'b0;
    logic        nBUSACK = 1'b1;
    logic        cpu_nRESET, cpu_nINT, cpu_nNMI, cpu_nBUSRQ;
    logic        busy;
    logic [3:0]  level;
    logic        tmo;

    z80_ctl_seq #(.DEPTH(DEPTH), .DELAY_W(16), .TMO_W(4)) dut (
        .CLK(CLK), .nRESET(nRESET),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_pin(push_pin), .push_level(push_level), .push_wack(push_wack),
        .push_delay(push_delay), .flush(flush), .tmo_clr(tmo_clr), .nBUSACK(nBUSACK),
        .cpu_nRESET(cpu_nRESET), .cpu_nINT(cpu_nINT), .cpu_nNMI(cpu_nNMI),
        .cpu_nBUSRQ(cpu_nBUSRQ), .busy(busy), .level(level), .tmo(tmo)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model: event schedule in absolute edge numbers
    typedef struct { int pin; bit lvl; bit wack; int dly; } ev_t;
    ev_t      q[$];
    ev_t      cur;
    ev_t      m_nv;
    int       cyc = 0;
    int       mode = 0;      // 0 nothing running, 1 waiting to apply, 2 waiting for ack
    int       apply_e = 0;
    int       dead_e = 0;
    int       m_sz0;
    bit       m_tnew;
    bit [3:0] m_pins = 4'b1110;
    bit       m_tmo = 1'b0;
    bit       mvalid = 1'b0;

    always @(posedge CLK) begin
        cyc = cyc + 1;
        if (!nRESET) begin
            q.delete(); mode = 0; m_pins = 4'b1110; m_tmo = 1'b0; mvalid = 1'b1;
        end else if (flush) begin
            q.delete(); mode = 0; m_tmo = m_tmo && !tmo_clr;
        end else begin
            m_sz0  = q.size();
            m_tnew = m_tmo && !tmo_clr;
            if (mode == 0) begin
                if (m_sz0 > 0) begin
                    cur = q.pop_front(); apply_e = cyc + cur.dly + 1; mode = 1;
                end
            end else if (mode == 1) begin
                if (cyc == apply_e) begin
                    m_pins[cur.pin] = cur.lvl;
                    if (cur.pin == 3 && !cur.lvl && cur.wack) begin
                        mode = 2; dead_e = cyc + LIMIT;
                    end else mode = 0;
                end
            end else begin
                if (!nBUSACK) mode = 0;
                else if (cyc == dead_e) begin
                    m_tnew = 1'b1; m_pins[3] = 1'b1; mode = 0;
                end
            end
            if (push_valid && m_sz0 < DEPTH) begin
                m_nv.pin = int'(push_pin); m_nv.lvl = push_level;
                m_nv.wack = push_wack; m_nv.dly = int'(push_delay);
                q.push_back(m_nv);
            end
            m_tmo = m_tnew;
        end
    end

    // ---------------- checking
    int n_total = 0;
    int n_bad = 0;

    task automatic tick();
        logic [10:0] exp_v, act_v;
        @(negedge CLK);
        if (mvalid) begin
            exp_v = {m_pins, m_tmo, 4'(q.size()), (mode != 0) || (q.size() > 0), q.size() < DEPTH};
            act_v = {cpu_nBUSRQ, cpu_nNMI, cpu_nINT, cpu_nRESET, tmo, level, busy, push_ready};
            n_total++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL cycle_outputs edge=%0d got=%b want=%b", cyc, act_v, exp_v);
            end
        end
    endtask

    task automatic to_edge(input int n);
        while (cyc < n) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", name, cyc, act, exp_v);
        end
    endtask

    task automatic set_push(input int pin, input bit lvl, input bit wack, input int d);
        push_valid = 1'b1; push_pin = 2'(pin); push_level = lvl;
        push_wack = wack; push_delay = 16'(d);
    endtask

    task automatic wait_idle(input int lim);
        int start;
        start = cyc;
        while (busy && cyc < start + lim) tick();
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    int ev_pin[8] = '{1, 2, 1, 0, 2, 1, 0, 0};
    int ev_lvl[8] = '{0, 0, 1, 1, 1, 1, 0, 1};
    int ev_dly[8] = '{2, 0, 1, 0, 3, 0, 1, 2};
    int b;

    initial begin
        // reset state
        to_edge(2);
        check("rst_pins", {cpu_nBUSRQ, cpu_nNMI, cpu_nINT, cpu_nRESET}, 4'b1110);
        check("rst_level", level, 0);
        check("rst_ready", push_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_tmo", tmo, 0);
        nRESET = 1'b1;

        // single event, delay 3, pushed on edge 5
        to_edge(4);  set_push(0, 1, 0, 3);
        to_edge(5);  push_valid = 1'b0;
        to_edge(9);  check("lat_before", cpu_nRESET, 0); check("lat_busy", busy, 1);
        to_edge(10); check("lat_apply", cpu_nRESET, 1);
        to_edge(11); check("lat_idle", busy, 0);

        // fill the FIFO behind a long stall event
        to_edge(20); set_push(2, 1, 0, 100);
        to_edge(21); push_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            to_edge(22 + i); set_push(ev_pin[i], ev_lvl[i][0], 0, ev_dly[i]);
        end
        to_edge(30); check("full_level", level, 8); check("full_ready", push_ready, 0);
        set_push(2, 0, 0, 0);
        to_edge(31); push_valid = 1'b0; check("refused_level", level, 8);
        to_edge(126); check("ev1_before", cpu_nINT, 1);
        to_edge(127); check("ev1_apply", cpu_nINT, 0);
        wait_idle(100);
        check("fill_final_pins", {cpu_nBUSRQ, cpu_nNMI, cpu_nINT, cpu_nRESET}, 4'b1111);

        // BUSRQ with acknowledge 5 cycles after apply
        b = cyc + 2;
        to_edge(b - 1); set_push(3, 0, 1, 0);
        to_edge(b);      push_valid = 1'b0;
        to_edge(b + 2);  check("ack_apply", cpu_nBUSRQ, 0); check("ack_busy", busy, 1);
        to_edge(b + 6);  nBUSACK = 1'b0;
        to_edge(b + 7);  check("ack_idle", busy, 0); check("ack_tmo", tmo, 0);
        to_edge(b + 10); check("ack_hold", cpu_nBUSRQ, 0);

        // BUSRQ timeout, then clear
        b = cyc + 2;
        to_edge(b - 1); nBUSACK = 1'b1; set_push(3, 0, 1, 0);
        to_edge(b);      push_valid = 1'b0;
        to_edge(b + 16); check("tmo_early", tmo, 0); check("tmo_early_rq", cpu_nBUSRQ, 0);
        to_edge(b + 17); check("tmo_set", tmo, 1); check("tmo_rq", cpu_nBUSRQ, 1);
        check("tmo_idle", busy, 0);
        to_edge(b + 18); tmo_clr = 1'b1;
        to_edge(b + 19); tmo_clr = 1'b0; check("tmo_clr", tmo, 0);

        // acknowledge on the timeout edge counts as acknowledge
        b = cyc + 2;
        to_edge(b - 1); set_push(3, 0, 1, 0);
        to_edge(b);      push_valid = 1'b0;
        to_edge(b + 16); nBUSACK = 1'b0;
        to_edge(b + 17); nBUSACK = 1'b1;
        check("edge_ack_tmo", tmo, 0); check("edge_ack_rq", cpu_nBUSRQ, 0);

        // timeout set wins over a same-edge clear
        b = cyc + 2;
        to_edge(b - 1); set_push(3, 0, 1, 0);
        to_edge(b);      push_valid = 1'b0;
        to_edge(b + 16); tmo_clr = 1'b1;
        to_edge(b + 17); tmo_clr = 1'b0; check("set_wins", tmo, 1);

        // flush mid-delay with three queued, same-edge push dropped
        b = cyc + 2;
        to_edge(b - 1); set_push(1, 0, 0, 20);
        to_edge(b);     set_push(2, 0, 0, 0);
        to_edge(b + 1); set_push(0, 0, 0, 0);
        to_edge(b + 2); set_push(3, 0, 0, 0);
        to_edge(b + 3); push_valid = 1'b0; check("flush_queued", level, 3);
        to_edge(b + 5); flush = 1'b1; set_push(2, 0, 0, 0);
        to_edge(b + 6); flush = 1'b0; push_valid = 1'b0;
        check("flush_level", level, 0); check("flush_busy", busy, 0); check("flush_int", cpu_nINT, 1);
        to_edge(b + 30);
        check("flush_pins", {cpu_nBUSRQ, cpu_nNMI, cpu_nINT, cpu_nRESET}, 4'b1111);

        // reset during ACKWAIT
        b = cyc + 2;
        to_edge(b - 1); set_push(1, 0, 0, 0);
        to_edge(b);     set_push(3, 0, 1, 0);
        to_edge(b + 1); push_valid = 1'b0;
        to_edge(b + 4); set_push(2, 0, 0, 5);
        to_edge(b + 5); push_valid = 1'b0;
        to_edge(b + 7);
        check("pre_rst_pins", {cpu_nBUSRQ, cpu_nINT}, 2'b00);
        check("pre_rst_level", level, 1); check("pre_rst_tmo", tmo, 1);
        nRESET = 1'b0; set_push(2, 0, 0, 0);
        to_edge(b + 8); nRESET = 1'b1; push_valid = 1'b0;
        check("rst2_pins", {cpu_nBUSRQ, cpu_nNMI, cpu_nINT, cpu_nRESET}, 4'b1110);
        check("rst2_level", level, 0); check("rst2_tmo", tmo, 0); check("rst2_busy", busy, 0);
        to_edge(b + 14); check("rst2_nmi", cpu_nNMI, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
